// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory bus arbiter: state encodings,
// side identifiers and the default watchdog limit.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_I = 2'b01,
    GNT_D = 2'b10
  } state_t;

  localparam logic SIDE_I = 1'b0;
  localparam logic SIDE_D = 1'b1;

  localparam int TIMEOUT_DEFAULT = 255;

  // One-hot {d_grant, i_grant} view of a state; IDLE maps to 2'b00.
  function automatic logic [1:0] grant_of(input state_t s);
    return {s == GNT_D, s == GNT_I};
  endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one physical memory port between the I-side
// refill path and the D-side path, with a hung-memory watchdog.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          i_req,
  input  logic [AW-1:0] i_a,
  output logic [DW-1:0] i_dout,
  output logic          i_ready,
  input  logic          d_req,
  input  logic          d_write,
  input  logic [AW-1:0] d_a,
  input  logic [DW-1:0] d_din,
  output logic [DW-1:0] d_dout,
  output logic          d_ready,
  output logic [AW-1:0] m_a,
  output logic [DW-1:0] m_d_w,
  output logic          m_access,
  output logic          m_write,
  input  logic [DW-1:0] m_d_r,
  input  logic          m_ready,
  output logic [1:0]    grant,
  output logic          timeout
);

  // Aborting on the cycle the counter would reach TIMEOUT gives exactly
  // TIMEOUT granted cycles before the grant is dropped.
  localparam logic [7:0] WDOG_LIMIT = 8'(TIMEOUT - 1);

  state_t     state, state_next;
  logic       last, last_next;
  logic [7:0] wdog, wdog_next;
  logic       timeout_next;
  logic       req_x;
  logic       side_x;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state   <= IDLE;
      grant   <= 2'b00;
      last    <= SIDE_I;
      wdog    <= '0;
      timeout <= 1'b0;
    end else begin
      state   <= state_next;
      grant   <= grant_of(state_next);
      last    <= last_next;
      wdog    <= wdog_next;
      timeout <= timeout_next;
    end
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next   = state;
    last_next    = last;
    wdog_next    = wdog;
    timeout_next = timeout;
    req_x        = (state == GNT_D) ? d_req : i_req;
    side_x       = (state == GNT_D) ? SIDE_D : SIDE_I;

    case (state)
      IDLE: begin
        wdog_next = '0;
        if (i_req && d_req) state_next = (last == SIDE_I) ? GNT_D : GNT_I;
        else if (i_req)     state_next = GNT_I;
        else if (d_req)     state_next = GNT_D;
      end
      GNT_I, GNT_D: begin
        if (!req_x) begin
          // Withdrawn requests leave the round-robin pointer untouched.
          state_next = IDLE;
        end else if (m_ready) begin
          state_next = IDLE;
          last_next  = side_x;
        end else if (wdog == WDOG_LIMIT) begin
          state_next   = IDLE;
          last_next    = side_x;
          timeout_next = 1'b1;
        end else begin
          wdog_next = wdog + 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    m_access = 1'b0;
    m_write  = 1'b0;
    m_a      = '0;
    m_d_w    = '0;
    case (state)
      GNT_I: begin
        m_access = i_req;
        m_a      = i_a;
      end
      GNT_D: begin
        m_access = d_req;
        m_write  = d_write;
        m_a      = d_a;
        m_d_w    = d_din;
      end
      default: ;
    endcase
  end

  assign i_ready = m_ready & grant[0] & i_req;
  assign d_ready = m_ready & grant[1] & d_req;
  assign i_dout  = m_d_r;
  assign d_dout  = m_d_r;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter: reset, single read,
// contention fairness, withdraw, watchdog abort and async reset.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        clr;
  logic        i_req, d_req, d_write, m_ready;
  logic [31:0] i_a, d_a, d_din, m_d_r;
  logic [31:0] i_dout, d_dout, m_a, m_d_w;
  logic        i_ready, d_ready, m_access, m_write, timeout;
  logic [1:0]  grant;

  int n_cmp = 0;
  int n_err = 0;

  mem_bus_arbiter #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
    .clk(clk), .clr(clr),
    .i_req(i_req), .i_a(i_a), .i_dout(i_dout), .i_ready(i_ready),
    .d_req(d_req), .d_write(d_write), .d_a(d_a), .d_din(d_din),
    .d_dout(d_dout), .d_ready(d_ready),
    .m_a(m_a), .m_d_w(m_d_w), .m_access(m_access), .m_write(m_write),
    .m_d_r(m_d_r), .m_ready(m_ready), .grant(grant), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle past the edge before driving/sampling.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    clr = 1'b1; i_req = 1'b0; d_req = 1'b0; d_write = 1'b0; m_ready = 1'b0;
    i_a = '0; d_a = '0; d_din = '0; m_d_r = '0;

    // 1: reset holds everything low even with both requests asserted
    i_req = 1'b1; d_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("rst_grant", 32'(grant), 32'h0);
      check("rst_access", 32'(m_access), 32'h0);
      check("rst_timeout", 32'(timeout), 32'h0);
    end
    i_req = 1'b0; d_req = 1'b0;
    #1 clr = 1'b0;
    step();
    check("idle_grant", 32'(grant), 32'h0);

    // 2: single I read, memory answers on the 4th grant cycle
    i_req = 1'b1; i_a = 32'h0000_0040;
    step();
    check("rd_grant", 32'(grant), 32'h1);
    check("rd_access", 32'(m_access), 32'h1);
    check("rd_addr", m_a, 32'h0000_0040);
    check("rd_write", 32'(m_write), 32'h0);
    check("rd_no_ready", 32'(i_ready), 32'h0);
    step(); step(); step();
    check("rd_hold_grant", 32'(grant), 32'h1);
    m_ready = 1'b1; m_d_r = 32'hDEAD_BEEF;
    #1;
    check("rd_i_ready", 32'(i_ready), 32'h1);
    check("rd_i_dout", i_dout, 32'hDEAD_BEEF);
    check("rd_d_ready", 32'(d_ready), 32'h0);
    step();
    m_ready = 1'b0; i_req = 1'b0;
    #1;
    check("rd_done_grant", 32'(grant), 32'h0);
    check("rd_done_ready", 32'(i_ready), 32'h0);
    check("rd_done_access", 32'(m_access), 32'h0);

    // 3: contention -> D first (last was I), idle gap, then I, then D
    i_req = 1'b1; d_req = 1'b1; d_write = 1'b1; d_a = 32'h100; d_din = 32'h1234;
    step();
    check("ct1_grant", 32'(grant), 32'h2);
    check("ct1_write", 32'(m_write), 32'h1);
    check("ct1_wdata", m_d_w, 32'h1234);
    check("ct1_addr", m_a, 32'h100);
    m_ready = 1'b1;
    #1;
    check("ct1_d_ready", 32'(d_ready), 32'h1);
    check("ct1_i_ready", 32'(i_ready), 32'h0);
    step();
    m_ready = 1'b0;
    #1;
    check("ct_gap_grant", 32'(grant), 32'h0);
    check("ct_gap_access", 32'(m_access), 32'h0);
    step();
    check("ct2_grant", 32'(grant), 32'h1);
    check("ct2_addr", m_a, 32'h40);
    check("ct2_write", 32'(m_write), 32'h0);
    check("ct2_wdata", m_d_w, 32'h0);
    m_ready = 1'b1;
    #1;
    check("ct2_i_ready", 32'(i_ready), 32'h1);
    check("ct2_d_ready", 32'(d_ready), 32'h0);
    step();
    m_ready = 1'b0;
    step();
    check("ct3_grant", 32'(grant), 32'h2);
    m_ready = 1'b1;
    #1;
    check("ct3_d_ready", 32'(d_ready), 32'h1);
    step();
    m_ready = 1'b0; i_req = 1'b0; d_req = 1'b0;

    // 4: withdraw D before m_ready; pending I is served afterwards
    d_req = 1'b1; d_write = 1'b0; d_a = 32'h200;
    step();
    check("wd_grant", 32'(grant), 32'h2);
    i_req = 1'b1;
    step();
    d_req = 1'b0;
    #1;
    check("wd_access", 32'(m_access), 32'h0);
    m_ready = 1'b1;
    #1;
    check("wd_ignored_ready", 32'(d_ready), 32'h0);
    m_ready = 1'b0;
    step();
    check("wd_idle", 32'(grant), 32'h0);
    check("wd_d_ready", 32'(d_ready), 32'h0);
    step();
    check("wd_i_grant", 32'(grant), 32'h1);
    m_ready = 1'b1;
    #1;
    check("wd_i_ready", 32'(i_ready), 32'h1);
    step();
    m_ready = 1'b0; i_req = 1'b0;

    // 5: watchdog, memory never answers: exactly 8 grant cycles then abort
    i_req = 1'b1; i_a = 32'h80;
    step();
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("wdg_grant_%0d", k), 32'(grant), 32'h1);
      check($sformatf("wdg_tmo_%0d", k), 32'(timeout), 32'h0);
      check($sformatf("wdg_ready_%0d", k), 32'(i_ready), 32'h0);
      step();
    end
    i_req = 1'b0;
    #1;
    check("wdg_abort_grant", 32'(grant), 32'h0);
    check("wdg_timeout", 32'(timeout), 32'h1);
    d_req = 1'b1; d_write = 1'b1; d_a = 32'h300; d_din = 32'h55AA;
    step();
    check("wdg_next_grant", 32'(grant), 32'h2);
    check("wdg_next_wdata", m_d_w, 32'h55AA);
    m_ready = 1'b1;
    #1;
    check("wdg_next_ready", 32'(d_ready), 32'h1);
    step();
    m_ready = 1'b0; d_req = 1'b0;
    #1;
    check("wdg_sticky", 32'(timeout), 32'h1);

    // 6: async reset in the middle of a D grant
    d_req = 1'b1;
    step();
    check("ar_pre_access", 32'(m_access), 32'h1);
    #1 clr = 1'b1;
    #1;
    check("ar_access", 32'(m_access), 32'h0);
    check("ar_grant", 32'(grant), 32'h0);
    check("ar_timeout", 32'(timeout), 32'h0);
    check("ar_write", 32'(m_write), 32'h0);
    d_req = 1'b0;
    step();
    clr = 1'b0;
    step();
    i_req = 1'b1; i_a = 32'h44;
    step();
    check("ar_after_grant", 32'(grant), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
